pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game controller for a two-paddle Pong on a VGA display.
//
// All game state advances only on cycles where frame_tick is high, so the block can run on the
// pixel clock and update once per frame. Every output is a register; an update made on tick
// cycle N is visible from cycle N+1.
//
// Ports
//   clk                    system (pixel-domain) clock
//   rst                    synchronous active-low reset
//   frame_tick             one-cycle pulse per frame; the only cycles that change state
//   btn_start              level; starts a game from IDLE or restarts it from OVER
//   up1, down1             left paddle controls (level)
//   up2, down2             right paddle controls (level, two-player build only)
//   ypos1, ypos2           paddle centres, vCount units
//   ball_x, ball_y         ball top-left corner (4x4 px ball)
//   score1, score2         player points, saturating at WIN_SCORE
//   state                  IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//   game_over              high while in OVER
//
// Build option
//   PONG_TWO_PLAYER_EN     defined: right paddle follows up2/down2.
//                          undefined: up2/down2 are ignored and the right paddle tracks the ball.

module pong_game_ctrl #(
    parameter int unsigned PADDLE_STEP  = 2,
    parameter int unsigned BALL_STEP    = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    output logic [9:0] ypos1,
    output logic [9:0] ypos2,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state,
    output logic       game_over
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } state_e;

    localparam int unsigned CntW = 16;

    localparam logic [9:0] PStep      = 10'(PADDLE_STEP);
    localparam logic [9:0] BStep      = 10'(BALL_STEP);
    localparam logic [9:0] PaddleMin  = 10'd55;
    localparam logic [9:0] PaddleMax  = 10'd495;
    localparam logic [9:0] PaddleInit = 10'd275;
    localparam logic [9:0] ServeX     = 10'd480;
    localparam logic [9:0] ServeY     = 10'd273;
    localparam logic [9:0] WallTop    = 10'd37;
    localparam logic [9:0] WallBot    = 10'd511;
    localparam logic [9:0] LeftHitLo  = 10'd169;
    localparam logic [9:0] LeftHitHi  = 10'd171;
    localparam logic [9:0] RightHitLo = 10'd757;
    localparam logic [9:0] RightHitHi = 10'd759;
    localparam logic [9:0] LeftMiss   = 10'd146;
    localparam logic [9:0] RightMiss  = 10'd780;

    localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);
    localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);

    // ---------------------------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------------------------
    state_e          state_q;
    logic [9:0]      ypos1_q, ypos2_q;
    logic [9:0]      ball_x_q, ball_y_q;
    logic            vx_neg_q, vy_neg_q;
    // Vertical direction used by the most recent serve; each new serve inverts it.
    logic            serve_vy_neg_q;
    logic [3:0]      score1_q, score2_q;
    logic [CntW-1:0] cnt_q;
    logic            game_over_q;

    // ---------------------------------------------------------------------------------------
    // Paddle next positions
    // ---------------------------------------------------------------------------------------
    // One paddle step with saturation at the play-field limits. Pressing both directions holds.
    function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up,
                                               input logic dn);
        logic [9:0] res;
        res = pos;
        if (up && !dn) begin
            if ({1'b0, pos} < ({1'b0, PaddleMin} + {1'b0, PStep})) begin
                res = PaddleMin;
            end else begin
                res = pos - PStep;
            end
        end else if (dn && !up) begin
            if (({1'b0, pos} + {1'b0, PStep}) > {1'b0, PaddleMax}) begin
                res = PaddleMax;
            end else begin
                res = pos + PStep;
            end
        end
        return res;
    endfunction

    logic       up2_eff, dn2_eff;
    logic [9:0] ypos1_nx, ypos2_nx;

`ifdef PONG_TWO_PLAYER_EN
    assign up2_eff = up2;
    assign dn2_eff = down2;
`else
    // Auto-tracking right paddle: chase the ball centre, with a dead band of one step so the
    // paddle does not dither once it is aligned.
    logic [10:0] track_tgt;
    logic        unused_player2;

    assign track_tgt      = {1'b0, ball_y_q} + 11'd2;
    assign up2_eff        = {1'b0, ypos2_q} > (track_tgt + {1'b0, PStep});
    assign dn2_eff        = track_tgt > ({1'b0, ypos2_q} + {1'b0, PStep});
    assign unused_player2 = up2 ^ down2;
`endif

    assign ypos1_nx = paddle_step(ypos1_q, up1, down1);
    assign ypos2_nx = paddle_step(ypos2_q, up2_eff, dn2_eff);

    // ---------------------------------------------------------------------------------------
    // Ball motion decisions for a PLAY tick
    // ---------------------------------------------------------------------------------------
    logic       vy_neg_nx, vx_neg_nx;
    logic       hit_left, hit_right;
    logic       miss_left, miss_right;
    logic [9:0] ball_x_nx, ball_y_nx;

    always_comb begin
        vy_neg_nx = vy_neg_q;
        if (vy_neg_q && (ball_y_q <= WallTop)) begin
            vy_neg_nx = 1'b0;
        end else if (!vy_neg_q && (ball_y_q >= WallBot)) begin
            vy_neg_nx = 1'b1;
        end

        // Window ypos-22 <= ball_y <= ypos+20, rewritten so nothing can underflow.
        hit_left  = vx_neg_q && (ball_x_q >= LeftHitLo) && (ball_x_q <= LeftHitHi) &&
                    (({1'b0, ball_y_q} + 11'd22) >= {1'b0, ypos1_q}) &&
                    ({1'b0, ball_y_q} <= ({1'b0, ypos1_q} + 11'd20));
        hit_right = !vx_neg_q && (ball_x_q >= RightHitLo) && (ball_x_q <= RightHitHi) &&
                    (({1'b0, ball_y_q} + 11'd22) >= {1'b0, ypos2_q}) &&
                    ({1'b0, ball_y_q} <= ({1'b0, ypos2_q} + 11'd20));

        vx_neg_nx = vx_neg_q;
        if (hit_left) begin
            vx_neg_nx = 1'b0;
        end else if (hit_right) begin
            vx_neg_nx = 1'b1;
        end

        // A paddle hit suppresses the miss test on the same tick.
        miss_left  = !hit_left && !hit_right && (ball_x_q <= LeftMiss);
        miss_right = !hit_left && !hit_right && !miss_left && (ball_x_q >= RightMiss);

        // The move always uses the freshly decided direction.
        ball_x_nx = vx_neg_nx ? (ball_x_q - BStep) : (ball_x_q + BStep);
        ball_y_nx = vy_neg_nx ? (ball_y_q - BStep) : (ball_y_q + BStep);
    end

    // ---------------------------------------------------------------------------------------
    // Game FSM and all registered outputs
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            ypos1_q        <= PaddleInit;
            ypos2_q        <= PaddleInit;
            ball_x_q       <= ServeX;
            ball_y_q       <= ServeY;
            vx_neg_q       <= 1'b0;
            vy_neg_q       <= 1'b0;
            serve_vy_neg_q <= 1'b0;
            score1_q       <= '0;
            score2_q       <= '0;
            cnt_q          <= '0;
            game_over_q    <= 1'b0;
        end else if (frame_tick) begin
            if (state_q != StIdle) begin
                ypos1_q <= ypos1_nx;
                ypos2_q <= ypos2_nx;
            end

            case (state_q)
                StIdle, StOver: begin
                    // A fresh game always opens with a right-and-down serve.
                    if (btn_start) begin
                        state_q        <= StServe;
                        score1_q       <= '0;
                        score2_q       <= '0;
                        cnt_q          <= '0;
                        ball_x_q       <= ServeX;
                        ball_y_q       <= ServeY;
                        vx_neg_q       <= 1'b0;
                        vy_neg_q       <= 1'b0;
                        serve_vy_neg_q <= 1'b0;
                        game_over_q    <= 1'b0;
                    end
                end

                StServe: begin
                    ball_x_q <= ServeX;
                    ball_y_q <= ServeY;
                    if (cnt_q == ServeLast) begin
                        state_q <= StPlay;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StPlay: begin
                    if (miss_left) begin
                        // Ball left unmoved; the loser of the point receives the next serve.
                        state_q  <= StPoint;
                        vx_neg_q <= 1'b1;
                        if (score2_q < WinScore) begin
                            score2_q <= score2_q + 1'b1;
                        end
                    end else if (miss_right) begin
                        state_q  <= StPoint;
                        vx_neg_q <= 1'b0;
                        if (score1_q < WinScore) begin
                            score1_q <= score1_q + 1'b1;
                        end
                    end else begin
                        ball_x_q <= ball_x_nx;
                        ball_y_q <= ball_y_nx;
                        vx_neg_q <= vx_neg_nx;
                        vy_neg_q <= vy_neg_nx;
                    end
                end

                StPoint: begin
                    if ((score1_q == WinScore) || (score2_q == WinScore)) begin
                        state_q     <= StOver;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q        <= StServe;
                        cnt_q          <= '0;
                        ball_x_q       <= ServeX;
                        ball_y_q       <= ServeY;
                        vy_neg_q       <= ~serve_vy_neg_q;
                        serve_vy_neg_q <= ~serve_vy_neg_q;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ypos1     = ypos1_q;
    assign ypos2     = ypos2_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule
